lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- MEM-stage load/store unit that converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the data memory interface.
- The data memory interface is MemRead, MemWrite, a 7-bit word address, 32-bit write data and 32-bit read data. Reads are combinational. Writes are level-sensitive with no byte enables.
- Sub-word stores are performed as a read-modify-write sequence.
- The pipeline sees a valid/ready request and a one-cycle response pulse, and stalls while the unit is busy.

Parameters:
- ADDR_W, 7, word-address width driven on mem_addr; selects byte-address bits [ADDR_W+1:2].
- XLEN, 32, data width; fixed at 32, present for documentation only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline presents a memory operation
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse at completion
- resp_rdata  out  32  extended load result; 0 for stores
- resp_err  out  1  qualified by resp_valid; misalign or illegal funct3
- mem_read  out  1  drives MemRead
- mem_write  out  1  drives MemWrite
- mem_addr  out  ADDR_W  drives the word address
- mem_wdata  out  32  drives DataInput
- mem_rdata  in  32  from DataOutput; valid combinationally while mem_read=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All of the following are 0: req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata. req_ready rises in the first cycle after reset release.
- On acceptance, register funct3, we, addr and wdata. req_* inputs are ignored outside IDLE.
- All mem_* outputs are registered and change only on clk edges. mem_read and mem_write are never high in the same cycle.
- mem_write is high for exactly one cycle per store. mem_addr and mem_wdata are stable for the whole of that cycle.
- States:
  - IDLE: on accept, go to RD if load or sub-word store; go to WR if SW; go to RESP with err=1 if the request is illegal.
  - RD: mem_read=1, mem_addr=addr[ADDR_W+1:2]. At the end of the cycle, capture mem_rdata. Load → RESP. Sub-word store → WR.
  - WR: mem_write=1, same mem_addr.
    - SW: mem_wdata = wdata.
    - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
    - SH: captured word with lane addr[1] replaced by wdata[15:0].
    - Next state is RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0 in this cycle.
- Load extraction:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half lane addr[1], sign- or zero-extended.
  - LW: full word.
- Latency from accept edge to resp_valid cycle:
  - LW/LB/LH/LBU/LHU: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Illegal funct3 (011, 110, 111, or 1xx with we=1): no memory access, resp_err=1, resp_rdata=0.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes. Byte address 0x200 maps to word 0.
- Back-to-back: req_ready returns high in the cycle after RESP, so the maximum issue rate is one operation per 3 cycles (4 for SB/SH).
- Reset mid-operation (any state): return immediately to IDLE and drop mem_write/mem_read asynchronously. No resp_valid is produced for the aborted operation. A partially completed RMW leaves memory unmodified because the write phase is the last phase.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: halfword access with addr[0]=1, or word access with addr[1:0]!=0, is not sent to memory. The unit goes IDLE→RESP with resp_err=1 and resp_rdata=0 (1-cycle latency).
- Undefined: misaligned low bits are forced aligned (H uses addr[1], W ignores addr[1:0]). The access proceeds normally and resp_err is only set for illegal funct3.

Test Plan:
- Reset then LW at 0x0000_0008 with memory word 2 = 0xDEADBEEF → mem_read pulse with mem_addr=2, then resp_valid 2 cycles after accept with resp_rdata=0xDEADBEEF and resp_err=0.
- LB at 0x0B, LBU at 0x0B, LH at 0x0A, LHU at 0x0A, all with word 2 = 0x80FF_1234 → resp_rdata = 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF respectively.
- SB at 0x09 with wdata 0x000000AB, word 2 = 0x11223344 → RD then WR with mem_wdata=0x1122AB44; one mem_write pulse; resp_valid 3 cycles after accept.
- SW at 0x1FC with wdata 0xCAFEF00D → no mem_read; mem_write with mem_addr=127 and mem_wdata=0xCAFEF00D; SW at 0x200 writes mem_addr=0.
- LH at 0x03 → with LSU_MISALIGN_TRAP_EN: no mem_read/mem_write, resp_err=1 after 1 cycle. Without it: mem_addr=0, upper half returned, resp_err=0. funct3=011 always gives resp_err=1.
- Assert rst_n=0 during the RD cycle of an SH → mem_read drops immediately; no mem_write and no resp_valid; memory unchanged; req_ready=1 one cycle after release.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store unit: byte-addressed RV32I loads/stores mapped onto a word-wide data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned H/W accesses instead of force-aligning them.
module lsu_mem_initiator #(
    parameter int ADDR_W = 7,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]      state;
    logic [2:0]      op_f3;
    logic            op_we;
    logic [1:0]      op_lane;
    logic [XLEN-1:0] op_wdata;

    logic            f3_legal;
    logic            misalign;
    logic            req_bad;
    logic            unused_addr_hi;

    // Address bits above the memory window wrap silently.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    always_comb begin
        f3_legal = 1'b0;
        misalign = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !req_we;
            default:                f3_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_bad = !f3_legal || misalign;
    end

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h000000, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0000, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        store_merge = r;
    endfunction

    // Every output is registered; each transition sets the outputs of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_f3      <= '0;
            op_we      <= 1'b0;
            op_lane    <= '0;
            op_wdata   <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_f3     <= req_funct3;
                        op_we     <= req_we;
                        op_lane   <= req_addr[1:0];
                        op_wdata  <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                            state     <= S_WR;
                            mem_write <= 1'b1;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= S_RD;
                            mem_read <= 1'b1;
                            mem_addr <= req_addr[ADDR_W+1:2];
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_RD: begin
                    if (op_we) begin
                        state     <= S_WR;
                        mem_write <= 1'b1;
                        mem_wdata <= store_merge(op_f3, op_lane, mem_rdata, op_wdata);
                    end else begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_extract(op_f3, op_lane, mem_rdata);
                    end
                end
                S_WR: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed self-checking bench for lsu_mem_initiator with a 128-word behavioural data memory.
module tb_lsu_mem_initiator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    logic        poke_en;
    logic [6:0]  poke_addr;
    logic [31:0] poke_data;

    int n_checks;
    int n_pass;
    int rd_cnt;
    int wr_cnt;
    int resp_cnt;
    int both_hi;
    logic [6:0]  last_rd_addr;
    logic [6:0]  last_wr_addr;
    logic [31:0] last_wr_data;

    lsu_mem_initiator #(.ADDR_W(7), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (poke_en)        mem[poke_addr] <= poke_data;
        else if (mem_write) mem[mem_addr]  <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_read) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_addr;
        end
        if (mem_write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
        if (resp_valid)             resp_cnt <= resp_cnt + 1;
        if (mem_read && mem_write)  both_hi  <= both_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic poke(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    // Issues one request; reports latency (cycles after the accept edge), response and access counts.
    task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int nrd, output int nwr);
        int rd0, wr0;
        wait_ready(tag);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat   = 0;
        rdata = 32'hxxxxxxxx;
        err   = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = k;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        #1;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    int          lat, nrd, nwr, wr_before, resp_before;
    logic [31:0] rdata;
    logic        err;

    initial begin
        n_checks = 0; n_pass = 0;
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0; both_hi = 0;
        last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        check("rst_mem_read",   32'(mem_read),   32'd0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        poke(7'd2, 32'hDEADBEEF);
        do_op("lw", 1'b0, 3'b010, 32'h0000_0008, 32'h0, lat, rdata, err, nrd, nwr);
        check("lw_lat",   32'(lat), 32'd2);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_err",   32'(err), 32'd0);
        check("lw_nrd",   32'(nrd), 32'd1);
        check("lw_addr",  32'(last_rd_addr), 32'd2);
        check("lw_nwr",   32'(nwr), 32'd0);

        poke(7'd2, 32'h80FF1234);
        do_op("lb", 1'b0, 3'b000, 32'h0B, 32'h0, lat, rdata, err, nrd, nwr);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        check("lb_lat",   32'(lat), 32'd2);
        do_op("lbu", 1'b0, 3'b100, 32'h0B, 32'h0, lat, rdata, err, nrd, nwr);
        check("lbu_rdata", rdata, 32'h00000080);
        do_op("lh", 1'b0, 3'b001, 32'h0A, 32'h0, lat, rdata, err, nrd, nwr);
        check("lh_rdata", rdata, 32'hFFFF80FF);
        do_op("lhu", 1'b0, 3'b101, 32'h0A, 32'h0, lat, rdata, err, nrd, nwr);
        check("lhu_rdata", rdata, 32'h000080FF);
        check("lhu_err",   32'(err), 32'd0);

        poke(7'd2, 32'h11223344);
        do_op("sb", 1'b1, 3'b000, 32'h09, 32'h000000AB, lat, rdata, err, nrd, nwr);
        check("sb_lat",   32'(lat), 32'd3);
        check("sb_nrd",   32'(nrd), 32'd1);
        check("sb_nwr",   32'(nwr), 32'd1);
        check("sb_wdata", last_wr_data, 32'h1122AB44);
        check("sb_waddr", 32'(last_wr_addr), 32'd2);
        check("sb_mem",   mem[2], 32'h1122AB44);
        check("sb_rdata", rdata, 32'd0);

        do_op("sw_top", 1'b1, 3'b010, 32'h1FC, 32'hCAFEF00D, lat, rdata, err, nrd, nwr);
        check("sw_top_lat",   32'(lat), 32'd2);
        check("sw_top_nrd",   32'(nrd), 32'd0);
        check("sw_top_nwr",   32'(nwr), 32'd1);
        check("sw_top_waddr", 32'(last_wr_addr), 32'd127);
        check("sw_top_wdata", last_wr_data, 32'hCAFEF00D);
        do_op("sw_wrap", 1'b1, 3'b010, 32'h200, 32'h12345678, lat, rdata, err, nrd, nwr);
        check("sw_wrap_waddr", 32'(last_wr_addr), 32'd0);
        check("sw_wrap_mem",   mem[0], 32'h12345678);

        do_op("lh_mis", 1'b0, 3'b001, 32'h03, 32'h0, lat, rdata, err, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lh_mis_err",   32'(err), 32'd1);
        check("lh_mis_lat",   32'(lat), 32'd1);
        check("lh_mis_rdata", rdata, 32'd0);
        check("lh_mis_nrd",   32'(nrd), 32'd0);
`else
        check("lh_mis_err",   32'(err), 32'd0);
        check("lh_mis_lat",   32'(lat), 32'd2);
        check("lh_mis_rdata", rdata, 32'h00001234);
        check("lh_mis_addr",  32'(last_rd_addr), 32'd0);
`endif

        do_op("f3_011", 1'b0, 3'b011, 32'h08, 32'h0, lat, rdata, err, nrd, nwr);
        check("f3_011_err",   32'(err), 32'd1);
        check("f3_011_lat",   32'(lat), 32'd1);
        check("f3_011_rdata", rdata, 32'd0);
        check("f3_011_nrd",   32'(nrd), 32'd0);
        do_op("sbu_ill", 1'b1, 3'b100, 32'h08, 32'hFF, lat, rdata, err, nrd, nwr);
        check("sbu_ill_err", 32'(err), 32'd1);
        check("sbu_ill_nwr", 32'(nwr), 32'd0);
        check("sbu_ill_mem", mem[2], 32'h1122AB44);

        // SH aborted by reset during its read phase.
        poke(7'd3, 32'h55667788);
        wait_ready("sh_abort");
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0E; req_wdata = 32'h0000BEEF;
        wr_before = wr_cnt;
        resp_before = resp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_rd_phase", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd_drop",  32'(mem_read),  32'd0);
        check("abort_wr_low",   32'(mem_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready",  32'(req_ready), 32'd1);
        check("abort_nwr",    32'(wr_cnt - wr_before), 32'd0);
        check("abort_nresp",  32'(resp_cnt - resp_before), 32'd0);
        check("abort_mem",    mem[3], 32'h55667788);

        do_op("lw_after", 1'b0, 3'b010, 32'h0C, 32'h0, lat, rdata, err, nrd, nwr);
        check("lw_after_rdata", rdata, 32'h55667788);
        check("lw_after_lat",   32'(lat), 32'd2);

        check("rd_wr_exclusive", 32'(both_hi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
